// File: rtl/hockey_pkg.sv
// Shared field geometry, paddle FSM encodings and small helpers for the
// air-hockey paddle/puck logic.
package hockey_pkg;

  localparam int FIELD_W  = 640;
  localparam int FIELD_H  = 480;
  localparam int PADDLE_R = 20;

  localparam logic [1:0] HOME     = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  typedef struct packed {
    logic [10:0] x_min;
    logic [10:0] x_max;
  } x_limits_t;

  // Each paddle is confined to its own half of the field.
  localparam x_limits_t LEFT_X_LIMITS  = '{x_min: 11'd40,  x_max: 11'd300};
  localparam x_limits_t RIGHT_X_LIMITS = '{x_min: 11'd340, x_max: 11'(FIELD_W - 2*PADDLE_R)};

  localparam int NUM_BTNS  = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SHOOT = 4;

  typedef enum logic [1:0] {SHOT_UP, SHOT_MID, SHOT_DOWN} shot_dir_e;

  function automatic shot_dir_e shot_dir(input logic up, input logic down);
    if (up && !down) return SHOT_UP;
    if (down && !up) return SHOT_DOWN;
    return SHOT_MID;
  endfunction

  // One axis step: widened to 12 bits so a decrement near zero cannot wrap
  // before the clamp; opposing or absent requests leave the position alone.
  function automatic logic [10:0] move_axis(input logic [10:0] pos,
                                            input logic        dec,
                                            input logic        inc,
                                            input logic [11:0] step,
                                            input logic [11:0] lo,
                                            input logic [11:0] hi);
    logic [11:0] p;
    logic [11:0] r;
    p = {1'b0, pos};
    r = p;
    if (dec && !inc) begin
      r = (p < lo + step) ? lo : p - step;
    end else if (inc && !dec) begin
      r = (p + step > hi) ? hi : p + step;
    end
    return r[10:0];
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchronizer followed by a debouncer: the clean level flips only
// after DEB_CYCLES consecutive synchronized samples disagree with it.
module btn_sync_debounce
  import hockey_pkg::*;
#(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle controller: debounced buttons drive a clamped paddle
// position and one-cycle shot-direction pulses for the puck FSM.
module paddle_ctrl
  import hockey_pkg::*;
#(
  parameter logic [10:0] X_HOME         = 11'd80,
  parameter logic [10:0] Y_HOME         = 11'(FIELD_H / 2),
  parameter logic [10:0] X_MIN          = LEFT_X_LIMITS.x_min,
  parameter logic [10:0] X_MAX          = LEFT_X_LIMITS.x_max,
  parameter logic [10:0] Y_MIN          = 11'(2 * PADDLE_R),
  parameter logic [10:0] Y_MAX          = 11'(FIELD_H - 2 * PADDLE_R),
  parameter int          STEP           = 4,
  parameter int          TICK_DIV       = 833_333,
  parameter int          DEB_CYCLES     = 500_000,
  parameter int          COOLDOWN_TICKS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_shoot,
  output logic [10:0] px,
  output logic [10:0] py,
  output logic        shot_up,
  output logic        shot_mid,
  output logic        shot_down,
  output logic [1:0]  state
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CDW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] clean;

  assign raw = {btn_shoot, btn_right, btn_left, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_deb
      btn_sync_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk  (clk),
        .reset(reset),
        .din  (raw[gi]),
        .dout (clean[gi])
      );
    end
  endgenerate

  logic [TW-1:0]  tick_cnt_q;
  logic           tick;
  logic [1:0]     state_q, state_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic [10:0]    px_q, px_d;
  logic [10:0]    py_q, py_d;
  logic [2:0]     shot_q, shot_d;  // {down, mid, up}
  logic           shoot_prev_q;
  logic           shoot_edge;
  shot_dir_e      dir;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign shoot_edge = clean[BTN_SHOOT] & ~shoot_prev_q;
  assign dir        = shot_dir(clean[BTN_UP], clean[BTN_DOWN]);

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    px_d    = px_q;
    py_d    = py_q;
    shot_d  = 3'b000;
    if (hold || state_q == HOME) begin
      px_d    = X_HOME;
      py_d    = Y_HOME;
      cd_d    = '0;
      state_d = hold ? HOME : ACTIVE;
    end else begin
      if (tick) begin
        px_d = move_axis(px_q, clean[BTN_LEFT], clean[BTN_RIGHT], 12'(STEP),
                         {1'b0, X_MIN}, {1'b0, X_MAX});
        py_d = move_axis(py_q, clean[BTN_UP], clean[BTN_DOWN], 12'(STEP),
                         {1'b0, Y_MIN}, {1'b0, Y_MAX});
      end
      if (state_q == COOLDOWN) begin
        // Shoot edges seen here are dropped, not remembered for later.
        if (cd_q == '0) begin
          state_d = ACTIVE;
        end else if (tick) begin
          cd_d = cd_q - 1'b1;
          if (cd_q == CDW'(1)) state_d = ACTIVE;
        end
      end else if (shoot_edge) begin
        case (dir)
          SHOT_UP:   shot_d = 3'b001;
          SHOT_DOWN: shot_d = 3'b100;
          default:   shot_d = 3'b010;
        endcase
        state_d = COOLDOWN;
        cd_d    = CDW'(COOLDOWN_TICKS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q   <= '0;
      state_q      <= HOME;
      cd_q         <= '0;
      px_q         <= X_HOME;
      py_q         <= Y_HOME;
      shot_q       <= 3'b000;
      shoot_prev_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick ? '0 : tick_cnt_q + 1'b1;
      state_q      <= state_d;
      cd_q         <= cd_d;
      px_q         <= px_d;
      py_q         <= py_d;
      shot_q       <= shot_d;
      shoot_prev_q <= clean[BTN_SHOOT];
    end
  end

  assign px        = px_q;
  assign py        = py_q;
  assign shot_up   = shot_q[0];
  assign shot_mid  = shot_q[1];
  assign shot_down = shot_q[2];
  assign state     = state_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomized scoreboard bench for paddle_ctrl with shortened timing constants;
// a cycle-level reference model queues expectations, a monitor pops and checks.
module tb_paddle_ctrl;

  localparam int TD   = 4;
  localparam int DEB  = 3;
  localparam int CDT  = 2;
  localparam int STP  = 4;
  localparam int XH   = 80;
  localparam int YH   = 240;
  localparam int XMIN = 40;
  localparam int XMAX = 300;
  localparam int YMIN = 40;
  localparam int YMAX = 440;

  logic        clk = 1'b0;
  logic        reset, hold;
  logic        b_up, b_down, b_left, b_right, b_shoot;
  logic [10:0] px, py;
  logic        shot_up, shot_mid, shot_down;
  logic [1:0]  state;

  always #5 clk = ~clk;

  paddle_ctrl #(
    .STEP          (STP),
    .TICK_DIV      (TD),
    .DEB_CYCLES    (DEB),
    .COOLDOWN_TICKS(CDT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .btn_up   (b_up),
    .btn_down (b_down),
    .btn_left (b_left),
    .btn_right(b_right),
    .btn_shoot(b_shoot),
    .px       (px),
    .py       (py),
    .shot_up  (shot_up),
    .shot_mid (shot_mid),
    .shot_down(shot_down),
    .state    (state)
  );

  typedef struct { int cyc; int dir; } shot_t;       // dir: 0 up, 1 mid, 2 down
  typedef struct { int px; int py; int st; } pos_t;

  shot_t shot_q[$];
  pos_t  pos_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  bit    started = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Reference model: mode 0 home, 1 active, 2 cooldown.
  int          m_px, m_py, m_mode, m_cd, m_since;
  logic [15:0] raw_h [5];
  bit          cln [5];
  bit          prev_shoot;
  initial begin
    logic [4:0] rv;
    bit         tk, all_diff;
    pos_t       pe;
    shot_t      se;
    forever begin
      @(posedge clk);
      cyc++;
      started = 1'b1;
      if (reset) begin
        for (int b = 0; b < 5; b++) begin
          raw_h[b] = '0;
          cln[b]   = 1'b0;
        end
        prev_shoot = 1'b0;
        m_mode = 0; m_cd = 0; m_px = XH; m_py = YH; m_since = 0;
      end else begin
        m_since++;
        tk = (m_since % TD) == 0;
        if (hold) begin
          m_mode = 0; m_cd = 0; m_px = XH; m_py = YH;
        end else if (m_mode == 0) begin
          m_mode = 1;
        end else begin
          if (tk) begin
            if (cln[0] && !cln[1]) m_py = (m_py - STP < YMIN) ? YMIN : m_py - STP;
            if (cln[1] && !cln[0]) m_py = (m_py + STP > YMAX) ? YMAX : m_py + STP;
            if (cln[2] && !cln[3]) m_px = (m_px - STP < XMIN) ? XMIN : m_px - STP;
            if (cln[3] && !cln[2]) m_px = (m_px + STP > XMAX) ? XMAX : m_px + STP;
          end
          if (m_mode == 1) begin
            if (cln[4] && !prev_shoot) begin
              se.cyc = cyc;
              se.dir = (cln[0] && !cln[1]) ? 0 : (cln[1] && !cln[0]) ? 2 : 1;
              shot_q.push_back(se);
              m_mode = 2;
              m_cd   = CDT;
            end
          end else begin
            if (m_cd == 0) m_mode = 1;
            else if (tk) begin
              m_cd--;
              if (m_cd == 0) m_mode = 1;
            end
          end
        end
        // Debounce: the synchronized sample at this edge is the raw level two
        // edges ago; flip once the last DEB samples all disagree.
        prev_shoot = cln[4];
        rv = {b_shoot, b_right, b_left, b_down, b_up};
        for (int b = 0; b < 5; b++) begin
          raw_h[b] = {raw_h[b][14:0], rv[b]};
          all_diff = 1'b1;
          for (int k = 2; k <= DEB + 1; k++)
            if (raw_h[b][k] == cln[b]) all_diff = 1'b0;
          if (all_diff) cln[b] = !cln[b];
        end
      end
      pe.px = m_px; pe.py = m_py; pe.st = m_mode;
      pos_q.push_back(pe);
    end
  end

  // Monitor: checks position/state every cycle and any shot pulse it sees.
  initial begin
    pos_t  e;
    shot_t s;
    int    n_hi, got_dir;
    forever begin
      @(negedge clk);
      if (started) begin
        if (pos_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pos_queue_empty cyc=%0d", cyc);
        end else begin
          e = pos_q.pop_front();
          chk("px", int'(px), e.px);
          chk("py", int'(py), e.py);
          chk("state", int'(state), e.st);
        end
        while (shot_q.size() > 0 && shot_q[0].cyc < cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL shot_missing cyc=%0d got=none exp_dir=%0d at cyc=%0d",
                   cyc, shot_q[0].dir, shot_q[0].cyc);
          void'(shot_q.pop_front());
        end
        n_hi = int'(shot_up) + int'(shot_mid) + int'(shot_down);
        if (n_hi != 0) begin
          chk("shot_onehot", n_hi, 1);
          got_dir = shot_up ? 0 : (shot_down ? 2 : 1);
          if (shot_q.size() > 0 && shot_q[0].cyc == cyc) begin
            s = shot_q.pop_front();
            chk("shot_dir", got_dir, s.dir);
          end else begin
            n_cmp++; n_bad++;
            $display("FAIL shot_unexpected cyc=%0d got_dir=%0d exp=none", cyc, got_dir);
          end
        end
      end
    end
  end

  task automatic drive(input bit h, input bit u, input bit d, input bit l,
                       input bit r, input bit s, input int n);
    hold = h; b_up = u; b_down = d; b_left = l; b_right = r; b_shoot = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b1;
    b_up = 0; b_down = 0; b_left = 0; b_right = 0; b_shoot = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 4);
    drive(0, 0, 0, 0, 0, 0, 40);                // idle: stays home, goes active
    drive(0, 1, 0, 0, 0, 0, 50 * TD + 20);      // up until saturated at Y_MIN
    drive(0, 1, 1, 0, 0, 0, 40);                // both: no movement
    drive(0, 0, 0, 0, 1, 0, 300);               // right until X_MAX
    drive(1, 0, 0, 0, 0, 0, 3);                 // hold snaps home
    drive(0, 0, 0, 0, 0, 0, 10);
    // Down shots with a quick re-press at varying tick phases.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0, 0, 8 + $urandom_range(0, 3));
      drive(0, 0, 1, 0, 0, 1, 3);
      drive(0, 0, 1, 0, 0, 0, 3);
      drive(0, 0, 1, 0, 0, 1, 4);
      drive(0, 0, 1, 0, 0, 0, 20);
    end
    drive(0, 0, 0, 0, 0, 1, 6);                 // neither -> mid
    drive(0, 0, 0, 0, 0, 0, 20);
    drive(0, 1, 1, 0, 0, 1, 6);                 // both -> mid
    drive(0, 1, 1, 0, 0, 0, 20);
    drive(0, 0, 0, 0, 0, 1, 2);                 // glitch: no shot
    drive(0, 0, 0, 0, 0, 0, 20);
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(1, 12));
    end
    drive(0, 0, 0, 0, 0, 0, 30);
    // Reset lands on the edge that would register the shot pulse.
    b_shoot = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 10);
    drive(0, 0, 0, 0, 0, 0, 20);
    chk("shots_outstanding", shot_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Per-player paddle controller that sits directly upstream of the puck state machine. It turns raw board buttons into a clamped paddle position (`px`/`py`) and single-cycle shot-direction pulses (`shot_up`/`shot_mid`/`shot_down`). The puck FSM consumes these as `Lx/Ly/Lup/Lmid/Ldown` or `Rx/Ry/Rup/Rmid/Rdown`. There is one instance per player; X limits keep each paddle on its own half of the 640x480 field.

## Interface
- `X_HOME`, 11'd80: paddle x after reset and while held.
- `Y_HOME`, 11'd240: paddle y after reset and while held.
- `X_MIN`, 11'd40: lowest legal x.
- `X_MAX`, 11'd300: highest legal x.
- `Y_MIN`, 11'd40: lowest legal y.
- `Y_MAX`, 11'd440: highest legal y.
- `STEP`, 4: pixels moved per movement tick.
- `TICK_DIV`, 833_333: clk cycles per movement tick (120 Hz at 100 MHz).
- `DEB_CYCLES`, 500_000: stable cycles required before a button level is accepted.
- `COOLDOWN_TICKS`, 30: movement ticks after a shot before another shot is allowed.
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `hold`, in, 1: 1 = game not running; the paddle parks at home.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_shoot`: in, 1 each; raw asynchronous buttons, active-high.
- `px`, out, 11: paddle centre x.
- `py`, out, 11: paddle centre y.
- `shot_up`, `shot_mid`, `shot_down`: out, 1 each; one-cycle pulses, at most one high per cycle.
- `state`, out, 2: debug view of the FSM state.

## Operation
- Each button passes through `btn_sync_debounce` (2-FF sync, then debounce). The clean level changes only after `DEB_CYCLES` consecutive identical synchronized samples.
- A free-running tick counter counts 0..`TICK_DIV`-1. `tick` is high for one cycle when the count wraps.
- FSM states: HOME=0, ACTIVE=1, COOLDOWN=2.
  - HOME: `px`=`X_HOME`, `py`=`Y_HOME`, no shots. Leave to ACTIVE on the first cycle with `hold`=0.
  - ACTIVE: move on `tick`. A clean rising edge of shoot fires one shot, then go to COOLDOWN and load the cooldown counter with `COOLDOWN_TICKS`.
  - COOLDOWN: movement continues. Shoot edges are ignored (not queued). The counter decrements on each `tick`; go to ACTIVE when it reaches 0.
  - `hold`=1 in ACTIVE or COOLDOWN returns to HOME next cycle. The cooldown counter clears and the position snaps home.
- Movement on `tick`, vertical:
  - up-only: `py` = max(`py`-`STEP`, `Y_MIN`).
  - down-only: `py` = min(`py`+`STEP`, `Y_MAX`).
  - both or neither: no change.
- Horizontal movement follows the same rules with left/right against `X_MIN`/`X_MAX`.
- Arithmetic is done in 12 bits so that `py`-`STEP` never wraps below 0. The result is clamped, then truncated to 11 bits.
- Shot direction is sampled from the clean up/down levels in the same cycle as the shoot edge:
  - up-only → `shot_up`.
  - down-only → `shot_down`.
  - both or neither → `shot_mid`.
- Shoot edge and `tick` in the same cycle: both take effect.

## Timing
- Reset values: `px`=`X_HOME`, `py`=`Y_HOME`, all shots 0, `state`=HOME, tick and cooldown counters 0, debounced levels 0.
- Button-to-clean latency: 2 sync cycles + `DEB_CYCLES`.
- Shot pulse: registered, asserted the cycle after the clean shoot rising edge, exactly 1 cycle wide.
- Position: registered, updates the cycle after `tick`.
- `reset` mid-operation overrides everything, including an in-flight shot pulse, which is forced to 0.
- The puck FSM samples the shot pulses every clk while holding the puck. Shots fired when the puck is not held are harmlessly ignored downstream.

## Structure
- Shared package `hockey_pkg` holds:
  - field constants FIELD_W=640, FIELD_H=480, PADDLE_R=20;
  - the paddle state encodings HOME/ACTIVE/COOLDOWN;
  - per-side default limits (left X 40..300, right X 340..600).
- Sub-module `btn_sync_debounce` (param `DEB_CYCLES`; ports `clk`, `reset`, `din`, `dout`) is instantiated 5 times.

## Test plan
Simulation overrides: `TICK_DIV`=4, `DEB_CYCLES`=3, `COOLDOWN_TICKS`=2, `STEP`=4.
- Reset then hold=0, no buttons → `px`=80, `py`=240 forever; state goes HOME→ACTIVE; no shot pulses.
- Hold `btn_up` 50 ticks → `py` falls by 4 per tick and saturates at 40, never 36 or a wrapped value. Then both up+down → `py` stays 40.
- `btn_right` held long → `px` saturates at 300. Then `hold`=1 → next cycle `px`=80, `py`=240, state HOME.
- `btn_down` held and shoot pressed → exactly one `shot_down` pulse one cycle after the clean edge. A second press within 2 ticks → no pulse. A press after cooldown → `shot_down` again.
- Shoot with neither up nor down → `shot_mid`. Shoot with up+down → `shot_mid`. Shoot glitch shorter than 3 cycles → no pulse.
- `reset` asserted in the cycle a shot pulse would fire → pulse stays 0, all outputs return to reset values.
